audio_adc: RTL and testbench
============================

Name: audio_adc

Overview:
- Receive-side counterpart of the codec DAC path. Deserialises the codec's I2S ADC stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT; codec is master) into 32-bit stereo frames on the system clock.
- Presents each frame through a one-entry valid/ready output register.
- Sits between the codec pins and the DSP/vumeter logic, in parallel with the DAC transmitter.

Parameters:
- SAMPLE_W, 16, bits per channel; frame width = 2*SAMPLE_W
- SYNC_STAGES, 2, synchroniser depth for the three codec inputs (min 2)

Ports:
- clk  in  1  system clock (50 MHz); must be >= 4x AUD_BCLK
- rst  in  1  reset
- AUD_BCLK  in  1  codec bit clock, asynchronous to clk
- AUD_ADCLRCK  in  1  codec ADC word clock; low = left, high = right
- AUD_ADCDAT  in  1  codec serial ADC data, MSB first
- data  out  2*SAMPLE_W  frame {left[SAMPLE_W-1:0], right[SAMPLE_W-1:0]}, two's complement
- valid  out  1  data holds an unconsumed frame
- ready  in  1  consumer accepts when valid && ready
- overrun  out  1  one-cycle pulse: a frame completed while the previous frame was unconsumed
- peak  out  SAMPLE_W  left-channel peak magnitude (see Optional Feature)
- peak_clr  in  1  clear peak

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset values: data=0, valid=0, overrun=0, peak=0; state=IDLE; bit counter=0; shift register=0.
- Synchronisation: AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT each pass through SYNC_STAGES flops with identical depth, which preserves their relative alignment.
- bclk_rise = synchronised BCLK high and its previous value low. All protocol actions occur only on cycles with bclk_rise.
- Edge detect: lrck_prev is captured on every bclk_rise. boundary = (lrck != lrck_prev) on a bclk_rise.
- States:
  - IDLE: wait for a boundary with lrck=0 (start of left) -> SKIP_L.
  - SKIP_L / SKIP_R: I2S one-bit delay. The boundary bclk_rise carries no data. The next bclk_rise shifts the MSB, then go to SHIFT_L / SHIFT_R with count=1.
  - SHIFT_L / SHIFT_R: on each bclk_rise, shift ADCDAT in at the LSB and increment count. When count reaches SAMPLE_W:
    - SHIFT_L: latch left, go to WAIT_R.
    - SHIFT_R: complete the frame, go to WAIT_L.
  - WAIT_R: bits ignored until a boundary with lrck=1 -> SKIP_R.
  - WAIT_L: bits ignored until a boundary with lrck=0 -> SKIP_L.
- Frame completion: happens on the cycle of the last right bit's bclk_rise. data <= {left, right}, valid <= 1 on the next clk edge. Latency is 1 clk after the synchronised last bclk_rise.
- Extra bits beyond SAMPLE_W in a slot are ignored.
- Short slot (boundary while in SHIFT_x):
  - Partial channel and any held left are discarded; no frame is produced.
  - lrck=0 at the boundary -> SKIP_L.
  - lrck=1 at the boundary -> WAIT_L (a right half without a left is never emitted).
- Handshake:
  - valid falls on the clk edge after valid && ready.
  - data is stable while valid=1 and not ready, except on overrun.
- Frame completes while valid=1 and ready=0: data is overwritten with the new frame, valid stays 1, overrun pulses 1 cycle.
- Frame completes on the same cycle as valid && ready: the new frame loads, valid stays 1, no overrun.
- rst mid-frame: all state cleared, back to IDLE; a fresh left boundary is required before any output.

Optional Feature:
- Macro AUDIO_ADC_PEAK_EN.
- Defined:
  - On each frame completion, peak <= max(peak, |left|).
  - |x| for the most negative value saturates to 2^(SAMPLE_W-1)-1.
  - peak_clr sets peak=0 on the next edge. If peak_clr and a frame completion coincide, peak <= |left|.
- Undefined: peak tied to 0, peak_clr ignored; no peak logic synthesised.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W default constant
  - adc_state_t enum {IDLE, SKIP_L, SHIFT_L, WAIT_R, SKIP_R, SHIFT_R, WAIT_L}
  - stereo frame typedef (packed struct left/right)
- Sub-module sync_edge: parameterised N-stage synchroniser with rise/fall outputs, instantiated for BCLK and LRCK; ADCDAT uses the data-only output.

Test Plan:
- Reset, then frame left=16'h1234, right=16'hABCD at BCLK=clk/16, ready=1 -> one valid pulse with data=32'h1234ABCD, overrun never asserted.
- Stream starts mid-right-slot after reset -> no valid until the first full left+right frame; first data equals the second transmitted frame's values.
- ready=0 across two frames 32'h00010002 then 32'h00030004 -> overrun pulses once; data=32'h00030004; valid stays 1 until ready.
- LRCK toggles after only 10 left bits, then a full frame 32'h7FFF8000 -> short frame dropped; only 32'h7FFF8000 emitted.
- rst asserted for 1 cycle at bit 8 of the right slot -> valid=0, data=0; next output is the next complete frame.
- With AUDIO_ADC_PEAK_EN, left=16'h8000 then 16'h0100 -> peak=16'h7FFF; peak_clr -> 0; next frame left=16'hFF00 -> peak=16'h0100.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the codec audio receive path.
//   DEFAULT_SAMPLE_W : default bits per channel
//   adc_state_t      : I2S receiver states
//   stereo_t         : packed {left, right} frame at the default width
package audio_pkg;

    localparam int unsigned DEFAULT_SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SKIP_L,
        SHIFT_L,
        WAIT_R,
        SKIP_R,
        SHIFT_R,
        WAIT_L
    } adc_state_t;

    typedef struct packed {
        logic [DEFAULT_SAMPLE_W-1:0] left;
        logic [DEFAULT_SAMPLE_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: N-stage synchroniser for one asynchronous input, with edge
// detection on the synchronised value.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_d          : asynchronous input
//   o_q          : synchronised level
//   o_rise       : one-cycle pulse on a synchronised 0->1 transition
//   o_fall       : one-cycle pulse on a synchronised 1->0 transition
module sync_edge #(
    parameter int unsigned N = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [N-1:0] r_sync;
    logic         r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
            r_prev <= r_sync[N-1];
        end
    end

    assign o_q    = r_sync[N-1];
    assign o_rise = r_sync[N-1] & ~r_prev;
    assign o_fall = ~r_sync[N-1] & r_prev;

endmodule

// File: rtl/audio_adc.sv
// audio_adc: I2S ADC receiver (codec is master). Deserialises AUD_ADCDAT into
// {left, right} frames on clk and presents them through a one-entry
// valid/ready register.
//   clk, rst     : system clock (>= 4x AUD_BCLK), synchronous active-high reset
//   AUD_BCLK     : codec bit clock (asynchronous)
//   AUD_ADCLRCK  : codec word clock, low = left, high = right
//   AUD_ADCDAT   : codec serial data, MSB first
//   data         : {left, right} two's complement frame
//   valid/ready  : output handshake
//   overrun      : one-cycle pulse when a frame overwrote an unconsumed one
//   peak         : left-channel peak magnitude
//   peak_clr     : clear peak
// Optional feature macro: AUDIO_ADC_PEAK_EN (peak tracking; peak reads 0
// and peak_clr is ignored when undefined).
module audio_adc
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = DEFAULT_SAMPLE_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [2*SAMPLE_W-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun,
    output logic [SAMPLE_W-1:0]   peak,
    input  logic                  peak_clr
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_W - 1);

    logic w_bclk_rise;
    logic w_lrck;
    logic w_dat;
    logic w_unused_bclk_q, w_unused_bclk_fall;
    logic w_unused_lrck_rise, w_unused_lrck_fall;
    logic w_unused_dat_rise, w_unused_dat_fall;

    // Same depth on all three pins keeps data/LRCK aligned to the BCLK rise.
    sync_edge #(.N(SYNC_STAGES)) u_sync_bclk (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (AUD_BCLK),
        .o_q   (w_unused_bclk_q),
        .o_rise(w_bclk_rise),
        .o_fall(w_unused_bclk_fall)
    );

    sync_edge #(.N(SYNC_STAGES)) u_sync_lrck (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (AUD_ADCLRCK),
        .o_q   (w_lrck),
        .o_rise(w_unused_lrck_rise),
        .o_fall(w_unused_lrck_fall)
    );

    sync_edge #(.N(SYNC_STAGES)) u_sync_dat (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (AUD_ADCDAT),
        .o_q   (w_dat),
        .o_rise(w_unused_dat_rise),
        .o_fall(w_unused_dat_fall)
    );

    adc_state_t            r_state;
    logic                  r_lrck_prev;
    logic [CNT_W-1:0]      r_count;
    logic [SAMPLE_W-1:0]   r_shift;
    logic [SAMPLE_W-1:0]   r_left;
    logic [2*SAMPLE_W-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    logic                  w_boundary;
    logic [SAMPLE_W-1:0]   w_shift_next;
    logic                  w_done;

    assign w_boundary   = (w_lrck != r_lrck_prev);
    assign w_shift_next = {r_shift[SAMPLE_W-2:0], w_dat};
    // Last right-channel bit arriving: the frame completes on this cycle.
    assign w_done       = w_bclk_rise && (r_state == SHIFT_R) && !w_boundary
                          && (r_count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lrck_prev <= 1'b0;
            r_count     <= '0;
            r_shift     <= '0;
            r_left      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            // A completing frame takes priority over the consumer's pop.
            if (w_done) begin
                r_data    <= {r_left, w_shift_next};
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !ready;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (w_bclk_rise) begin
                r_lrck_prev <= w_lrck;
                case (r_state)
                    IDLE: begin
                        if (w_boundary && !w_lrck) r_state <= SKIP_L;
                    end
                    SKIP_L, SKIP_R, SHIFT_L, SHIFT_R: begin
                        if (w_boundary) begin
                            // Short slot: drop everything; a right half with
                            // no preceding left must wait for the next left.
                            r_left  <= '0;
                            r_state <= w_lrck ? WAIT_L : SKIP_L;
                        end else if (r_state == SKIP_L || r_state == SKIP_R) begin
                            r_shift <= w_shift_next;
                            r_count <= CNT_W'(1);
                            r_state <= (r_state == SKIP_L) ? SHIFT_L : SHIFT_R;
                        end else begin
                            r_shift <= w_shift_next;
                            r_count <= r_count + 1'b1;
                            if (r_count == LAST_CNT) begin
                                if (r_state == SHIFT_L) begin
                                    r_left  <= w_shift_next;
                                    r_state <= WAIT_R;
                                end else begin
                                    r_state <= WAIT_L;
                                end
                            end
                        end
                    end
                    WAIT_R: begin
                        if (w_boundary && w_lrck) r_state <= SKIP_R;
                    end
                    WAIT_L: begin
                        if (w_boundary && !w_lrck) r_state <= SKIP_L;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign overrun = r_overrun;

`ifdef AUDIO_ADC_PEAK_EN
    logic [SAMPLE_W-1:0] r_peak;
    logic [SAMPLE_W-1:0] w_left_abs;
    logic [SAMPLE_W-1:0] w_peak_base;

    // Magnitude of the held left sample; the most negative code saturates.
    always_comb begin
        w_left_abs = r_left;
        if (r_left[SAMPLE_W-1]) begin
            if (r_left == {1'b1, {(SAMPLE_W-1){1'b0}}})
                w_left_abs = {1'b0, {(SAMPLE_W-1){1'b1}}};
            else
                w_left_abs = ~r_left + 1'b1;
        end
    end

    // A clear coinciding with a frame restarts the peak from that frame.
    assign w_peak_base = peak_clr ? '0 : r_peak;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak <= '0;
        end else if (w_done) begin
            r_peak <= (w_left_abs > w_peak_base) ? w_left_abs : w_peak_base;
        end else if (peak_clr) begin
            r_peak <= '0;
        end
    end

    assign peak = r_peak;
`else
    logic w_unused_peak_clr;
    assign w_unused_peak_clr = peak_clr;
    assign peak = '0;
`endif

endmodule

// File: tb/tb_audio_adc.sv
// tb_audio_adc: directed bench for audio_adc. Drives an I2S stream at
// BCLK = clk/16, each slot = one delay bit + data bits + padding.
module tb_audio_adc;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        AUD_BCLK;
    logic        AUD_ADCLRCK;
    logic        AUD_ADCDAT;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        overrun;
    logic [15:0] peak;
    logic        peak_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    logic [31:0] q[$];

    audio_adc #(.SAMPLE_W(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .AUD_BCLK   (AUD_BCLK),
        .AUD_ADCLRCK(AUD_ADCLRCK),
        .AUD_ADCDAT (AUD_ADCDAT),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .peak       (peak),
        .peak_clr   (peak_clr)
    );

    always #10 clk = ~clk;

    // Record every accepted frame and every overrun pulse.
    always @(negedge clk) begin
        if (valid && ready) q.push_back(data);
        if (overrun) ovr_cnt++;
    end

    task automatic send_bit(input logic l, input logic d);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = l;
        AUD_ADCDAT  = d;
        repeat (8) @(negedge clk);
        AUD_BCLK = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_slot(input logic l, input logic [15:0] s,
                             input int nbits, input int total);
        send_bit(l, 1'b0);
        for (int i = 0; i < total - 1; i++)
            send_bit(l, (i < nbits) ? s[15-i] : 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 16, 18);
        send_slot(1'b1, r, 16, 18);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_tests++;
        if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", data); end
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_tests++;
        if (peak !== 16'h0) begin n_fail++; $display("FAIL reset_peak: got %h want 0000", peak); end
    endtask

    task automatic test_basic_frame();
        q.delete(); ovr_cnt = 0;
        send_slot(1'b1, 16'h0, 0, 2);
        send_frame(16'h1234, 16'hABCD);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d frames want 1", q.size()); end
        else begin
            n_tests++;
            if (q[0] !== 32'h1234ABCD) begin n_fail++; $display("FAIL basic_data: got %h want 1234abcd", q[0]); end
        end
        n_tests++;
        if (ovr_cnt != 0) begin n_fail++; $display("FAIL basic_overrun: got %0d pulses want 0", ovr_cnt); end
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", valid); end
    endtask

    task automatic test_mid_stream_start();
        do_reset();
        q.delete();
        // Tail of a right slot: last 8 bits of 16'h6666.
        for (int i = 8; i < 16; i++) send_bit(1'b1, (16'h6666 >> (15 - i)) & 1'b1);
        send_bit(1'b1, 1'b0);
        send_frame(16'h0A0B, 16'h0C0D);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL midstart_count: got %0d frames want 1", q.size()); end
        else begin
            n_tests++;
            if (q[0] !== 32'h0A0B0C0D) begin n_fail++; $display("FAIL midstart_data: got %h want 0a0b0c0d", q[0]); end
        end
    endtask

    task automatic test_overrun();
        q.delete(); ovr_cnt = 0;
        ready = 1'b0;
        send_frame(16'h0001, 16'h0002);
        n_tests++;
        if (valid !== 1'b1 || data !== 32'h00010002) begin
            n_fail++; $display("FAIL ovr_first: got valid=%b data=%h want 1/00010002", valid, data);
        end
        send_frame(16'h0003, 16'h0004);
        n_tests++;
        if (ovr_cnt != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt); end
        n_tests++;
        if (valid !== 1'b1 || data !== 32'h00030004) begin
            n_fail++; $display("FAIL ovr_second: got valid=%b data=%h want 1/00030004", valid, data);
        end
        ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_release: got valid=%b want 0", valid); end
        n_tests++;
        if (q.size() != 1 || q[0] !== 32'h00030004) begin
            n_fail++; $display("FAIL ovr_accepted: got %0d frames (first %h) want 1 frame 00030004",
                               q.size(), (q.size() > 0) ? q[0] : 32'h0);
        end
    endtask

    task automatic test_short_slot();
        q.delete();
        send_slot(1'b0, 16'hFFFF, 10, 11);
        send_slot(1'b1, 16'h1111, 16, 18);
        send_frame(16'h7FFF, 16'h8000);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL short_count: got %0d frames want 1", q.size()); end
        else begin
            n_tests++;
            if (q[0] !== 32'h7FFF8000) begin n_fail++; $display("FAIL short_data: got %h want 7fff8000", q[0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        ready = 1'b0;
        send_frame(16'hAAAA, 16'h5555);
        n_tests++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", valid); end
        send_slot(1'b0, 16'h1357, 16, 18);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || data !== 32'h0) begin
            n_fail++; $display("FAIL midrst_clear: got valid=%b data=%h want 0/00000000", valid, data);
        end
        ready = 1'b1;
        q.delete();
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b1);
        send_frame(16'h2468, 16'hACE0);
        n_tests++;
        if (q.size() != 1 || q[0] !== 32'h2468ACE0) begin
            n_fail++; $display("FAIL midrst_next: got %0d frames (first %h) want 1 frame 2468ace0",
                               q.size(), (q.size() > 0) ? q[0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        stereo_t exp [3];
        exp[0] = '{left: 16'h1111, right: 16'h2222};
        exp[1] = '{left: 16'h3333, right: 16'h4444};
        exp[2] = '{left: 16'h5555, right: 16'h6666};
        q.delete();
        for (int i = 0; i < 3; i++) send_frame(exp[i].left, exp[i].right);
        n_tests++;
        if (q.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d frames want 3", q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, q[i], exp[i]); end
            end
        end
    endtask

    task automatic test_peak();
`ifdef AUDIO_ADC_PEAK_EN
        send_frame(16'h8000, 16'h0000);
        n_tests++;
        if (peak !== 16'h7FFF) begin n_fail++; $display("FAIL peak_neg_sat: got %h want 7fff", peak); end
        send_frame(16'h0100, 16'h0000);
        n_tests++;
        if (peak !== 16'h7FFF) begin n_fail++; $display("FAIL peak_hold: got %h want 7fff", peak); end
        @(negedge clk) peak_clr = 1'b1;
        @(negedge clk) peak_clr = 1'b0;
        n_tests++;
        if (peak !== 16'h0000) begin n_fail++; $display("FAIL peak_clear: got %h want 0000", peak); end
        send_frame(16'hFF00, 16'h0000);
        n_tests++;
        if (peak !== 16'h0100) begin n_fail++; $display("FAIL peak_after_clr: got %h want 0100", peak); end
`else
        send_frame(16'h8000, 16'h0000);
        @(negedge clk) peak_clr = 1'b1;
        @(negedge clk) peak_clr = 1'b0;
        n_tests++;
        if (peak !== 16'h0000) begin n_fail++; $display("FAIL peak_disabled: got %h want 0000", peak); end
`endif
    endtask

    initial begin
        rst         = 1'b1;
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = 1'b1;
        AUD_ADCDAT  = 1'b0;
        ready       = 1'b1;
        peak_clr    = 1'b0;
        test_reset();
        test_basic_frame();
        test_mid_stream_start();
        test_overrun();
        test_short_slot();
        test_reset_mid_frame();
        test_back_to_back();
        test_peak();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
